// File: rtl/lfsr_pkg.sv
// rtl/lfsr_pkg.sv - shared types, constants and helpers for the LFSR PRNG
//
// Purpose: FSM state encoding, default 32-bit tap/seed constants and the
//          steps-per-word clamp used by lfsr_prng_gen.
// Ports:   none (package)
package lfsr_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } lfsr_fsm_t;

  // Taps 31, 21, 1, 0.
  localparam logic [31:0] LFSR_TAPS_32 = 32'h8020_0003;
  localparam logic [31:0] LFSR_SEED_32 = 32'h0000_0001;

  // A request of 0 shifts still produces a word (1 shift).
  // Requests above N saturate at N, so the counter never wraps inside a word.
  function automatic int clamp_steps(input int req, input int n);
    if (req == 0) begin
      return 1;
    end else if (req > n) begin
      return n;
    end else begin
      return req;
    end
  endfunction

endpackage

// File: rtl/lfsr_prng_gen_step.sv
// rtl/lfsr_prng_gen_step.sv - combinational single-shift Fibonacci LFSR step
//
// Purpose: computes one Fibonacci shift of the state and flags an all-zero
//          result so the caller can substitute the default seed.
// Ports:   i_state  - current state (N bits)
//          o_next   - state after one shift (N bits)
//          o_zero   - o_next is all zeros
module lfsr_step
  import lfsr_pkg::*;
#(
  parameter int            N    = 32,
  parameter logic [N-1:0]  TAPS = N'(LFSR_TAPS_32)
) (
  input  logic [N-1:0] i_state,
  output logic [N-1:0] o_next,
  output logic         o_zero
);

  logic w_feedback;

  assign w_feedback = ^(i_state & TAPS);
  assign o_next     = {i_state[N-2:0], w_feedback};
  assign o_zero     = (o_next == '0);

endmodule

// File: rtl/lfsr_prng_gen.sv
// rtl/lfsr_prng_gen.sv - parametrised Fibonacci LFSR PRNG with valid/ready output
//
// Purpose: generates N-bit pseudo-random words, k shifts per word, with
//          runtime seed load, pause/resume and all-zero lockup recovery.
// Ports:   clk        - clock
//          reset_n    - asynchronous active-low reset
//          seed_in    - seed value (N bits)
//          seed_load  - single-cycle load strobe, highest priority
//          enable     - run/pause
//          steps      - shifts per word (0 -> 1, >N -> N)
//          out_valid  - word available on data_out
//          out_ready  - consumer accepts the word
//          data_out   - generated word, stable while out_valid=1
//          lock_err   - sticky: a zero state was substituted
//          busy       - FSM is in RUN
module lfsr_prng_gen
  import lfsr_pkg::*;
#(
  parameter int            N            = 32,
  parameter logic [N-1:0]  TAPS         = N'(LFSR_TAPS_32),
  parameter logic [N-1:0]  DEFAULT_SEED = N'(LFSR_SEED_32),
  parameter int            SW           = $clog2(N) + 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [N-1:0]  seed_in,
  input  logic          seed_load,
  input  logic          enable,
  input  logic [SW-1:0] steps,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  data_out,
  output logic          lock_err,
  output logic          busy
);

  lfsr_fsm_t     r_fsm;
  logic [N-1:0]  r_state;
  logic [N-1:0]  r_data;
  logic          r_valid;
  logic          r_lock;
  logic [SW-1:0] r_cnt;
  logic [SW-1:0] r_k;
  // Set for the first RUN cycle after a load: the freshly loaded seed is
  // held for one cycle before shifting, so a word after a load arrives at
  // load+1+k+1.
  logic          r_fresh;

  logic [N-1:0]  w_next;
  logic          w_zero;
  logic [N-1:0]  w_next_sub;
  logic [SW-1:0] w_k;
  logic [SW-1:0] w_cnt_inc;

  lfsr_step #(
    .N    (N),
    .TAPS (TAPS)
  ) u_step (
    .i_state (r_state),
    .o_next  (w_next),
    .o_zero  (w_zero)
  );

  assign w_next_sub = w_zero ? DEFAULT_SEED : w_next;
  assign w_k        = SW'(clamp_steps(int'(steps), N));
  assign w_cnt_inc  = r_cnt + SW'(1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_fsm   <= ST_IDLE;
      r_state <= DEFAULT_SEED;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_lock  <= 1'b0;
      r_cnt   <= '0;
      r_k     <= '0;
      r_fresh <= 1'b0;
    end else if (seed_load) begin
      // Load wins over everything, including a handshake in the same cycle.
      r_state <= (seed_in == '0) ? DEFAULT_SEED : seed_in;
      r_lock  <= (seed_in == '0);
      r_cnt   <= '0;
      r_valid <= 1'b0;
      r_fresh <= enable;
      if (enable) begin
        r_fsm <= ST_RUN;
        r_k   <= w_k;
      end else begin
        r_fsm <= ST_IDLE;
      end
    end else begin
      r_fresh <= 1'b0;
      case (r_fsm)
        ST_IDLE: begin
          if (enable) begin
            r_fsm <= ST_RUN;
            // A paused word in progress keeps the k it started with.
            if (r_cnt == '0) begin
              r_k <= w_k;
            end
          end
        end
        ST_RUN: begin
          if (!enable) begin
            r_fsm <= ST_IDLE;
          end else if (!r_fresh) begin
            r_state <= w_next_sub;
            if (w_zero) begin
              r_lock <= 1'b1;
            end
            if (w_cnt_inc == r_k) begin
              r_cnt   <= '0;
              r_data  <= w_next_sub;
              r_valid <= 1'b1;
              r_fsm   <= ST_HOLD;
            end else begin
              r_cnt <= w_cnt_inc;
            end
          end
        end
        ST_HOLD: begin
          if (r_valid && out_ready) begin
            r_valid <= 1'b0;
            if (enable) begin
              r_fsm <= ST_RUN;
              r_k   <= w_k;
            end else begin
              r_fsm <= ST_IDLE;
            end
          end
        end
        default: r_fsm <= ST_IDLE;
      endcase
    end
  end

  assign out_valid = r_valid;
  assign data_out  = r_data;
  assign lock_err  = r_lock;
  assign busy      = (r_fsm == ST_RUN);

endmodule

// File: tb/tb_lfsr_prng_gen.sv
// tb/tb_lfsr_prng_gen.sv - directed self-checking bench for lfsr_prng_gen
module tb_lfsr_prng_gen;

  logic        clk;
  logic        reset_n;

  logic [31:0] s_seed;
  logic        s_load;
  logic        s_en;
  logic [5:0]  s_steps;
  logic        s_ready;
  logic        s_valid;
  logic [31:0] s_data;
  logic        s_lock;
  logic        s_busy;

  logic [7:0]  e_seed;
  logic        e_load;
  logic        e_en;
  logic [3:0]  e_steps;
  logic        e_ready;
  logic        e_valid;
  logic [7:0]  e_data;
  logic        e_lock;
  logic        e_busy;

  int n_cmp = 0;
  int n_err = 0;

  lfsr_prng_gen dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .seed_in   (s_seed),
    .seed_load (s_load),
    .enable    (s_en),
    .steps     (s_steps),
    .out_valid (s_valid),
    .out_ready (s_ready),
    .data_out  (s_data),
    .lock_err  (s_lock),
    .busy      (s_busy)
  );

  lfsr_prng_gen #(
    .N            (8),
    .TAPS         (8'h01),
    .DEFAULT_SEED (8'h01)
  ) dut8 (
    .clk       (clk),
    .reset_n   (reset_n),
    .seed_in   (e_seed),
    .seed_load (e_load),
    .enable    (e_en),
    .steps     (e_steps),
    .out_valid (e_valid),
    .out_ready (e_ready),
    .data_out  (e_data),
    .lock_err  (e_lock),
    .busy      (e_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse seed_load for one edge; afterwards the load is visible (cycle 1).
  task automatic load32(input logic [31:0] seed);
    s_seed = seed;
    s_load = 1'b1;
    tick();
    s_load = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0;
    s_seed = '0; s_load = 0; s_en = 0; s_steps = '0; s_ready = 0;
    e_seed = '0; e_load = 0; e_en = 0; e_steps = '0; e_ready = 0;
    tick(); tick();
    chk("rst_valid", 32'(s_valid), 32'd0);
    chk("rst_data",  s_data,       32'd0);
    chk("rst_lock",  32'(s_lock),  32'd0);
    chk("rst_busy",  32'(s_busy),  32'd0);
    reset_n = 1'b1;
    tick();

    // steps=1, free-running consumer: 3, 6, D, one word every 2 cycles
    s_en = 1; s_steps = 6'd1; s_ready = 1;
    load32(32'h1);
    chk("t1_busy_c1",  32'(s_busy),  32'd1);
    chk("t1_valid_c1", 32'(s_valid), 32'd0);
    tick();
    chk("t1_valid_c2", 32'(s_valid), 32'd0);
    tick();
    chk("t1_valid_w0", 32'(s_valid), 32'd1);
    chk("t1_data_w0",  s_data,       32'h3);
    tick();
    chk("t1_gap0",     32'(s_valid), 32'd0);
    tick();
    chk("t1_valid_w1", 32'(s_valid), 32'd1);
    chk("t1_data_w1",  s_data,       32'h6);
    tick();
    chk("t1_gap1",     32'(s_valid), 32'd0);
    tick();
    chk("t1_valid_w2", 32'(s_valid), 32'd1);
    chk("t1_data_w2",  s_data,       32'hD);
    s_en = 0;
    tick();
    chk("t1_idle_valid", 32'(s_valid), 32'd0);
    chk("t1_idle_busy",  32'(s_busy),  32'd0);

    // steps=3: first word D at cycle 5, second 6D four cycles later
    s_en = 1; s_steps = 6'd3;
    load32(32'h1);
    tick(); tick(); tick();
    chk("t2_valid_c4", 32'(s_valid), 32'd0);
    tick();
    chk("t2_valid_c5", 32'(s_valid), 32'd1);
    chk("t2_data_w0",  s_data,       32'hD);
    tick(); tick(); tick();
    chk("t2_valid_c8", 32'(s_valid), 32'd0);
    tick();
    chk("t2_valid_c9", 32'(s_valid), 32'd1);
    chk("t2_data_w1",  s_data,       32'h6D);

    // Backpressure: word held while out_ready=0, also across enable=0
    s_steps = 6'd1; s_ready = 0;
    load32(32'h1);
    tick(); tick();
    chk("t3_valid_w0", 32'(s_valid), 32'd1);
    chk("t3_data_w0",  s_data,       32'h3);
    for (int i = 0; i < 5; i++) begin
      if (i == 3) s_en = 0;
      tick();
      chk("t3_hold_valid", 32'(s_valid), 32'd1);
      chk("t3_hold_data",  s_data,       32'h3);
    end
    s_en = 1; s_ready = 1;
    tick();
    chk("t3_accept", 32'(s_valid), 32'd0);
    tick();
    chk("t3_valid_w1", 32'(s_valid), 32'd1);
    chk("t3_data_w1",  s_data,       32'h6);

    // Zero seed substitution and lock_err clear on a nonzero load
    load32(32'h0);
    chk("t4_lock_set", 32'(s_lock), 32'd1);
    tick(); tick();
    chk("t4_sub_word", s_data,       32'h3);
    chk("t4_sub_vld",  32'(s_valid), 32'd1);
    load32(32'h5);
    chk("t4_lock_clr", 32'(s_lock), 32'd0);
    tick(); tick();
    chk("t4_word5", s_data, 32'hB);

    // steps=0 behaves as steps=1
    s_steps = 6'd0;
    load32(32'h1);
    tick(); tick();
    chk("t5_zero_steps", s_data, 32'h3);

    // N=8, taps 0x01: shift from 0x80 yields zero -> substituted 0x01
    e_en = 1; e_steps = 4'd1; e_ready = 1; e_seed = 8'h80; e_load = 1;
    tick();
    e_load = 0;
    chk("t6_lock_load", 32'(e_lock), 32'd0);
    tick(); tick();
    chk("t6_valid", 32'(e_valid), 32'd1);
    chk("t6_data",  32'(e_data),  32'h01);
    chk("t6_lock",  32'(e_lock),  32'd1);
    // steps=15 clamps to 8: word 0xFF at cycle 10
    e_steps = 4'd15; e_load = 1;
    tick();
    e_load = 0;
    repeat (8) tick();
    chk("t6_clamp_c9",  32'(e_valid), 32'd0);
    tick();
    chk("t6_clamp_c10", 32'(e_valid), 32'd1);
    chk("t6_clamp_dat", 32'(e_data),  32'hFF);
    e_en = 0;

    // seed_load while HOLD with out_ready=1: load wins, word dropped
    s_steps = 6'd1; s_ready = 0;
    load32(32'h1);
    tick(); tick();
    chk("t7_hold_data", s_data, 32'h3);
    s_ready = 1;
    load32(32'h5);
    chk("t7_drop_c1", 32'(s_valid), 32'd0);
    tick();
    chk("t7_drop_c2", 32'(s_valid), 32'd0);
    tick();
    chk("t7_new_vld",  32'(s_valid), 32'd1);
    chk("t7_new_data", s_data,       32'hB);

    // Asynchronous reset mid-RUN
    s_steps = 6'd8;
    load32(32'h0);
    tick();
    chk("t8_busy_pre", 32'(s_busy), 32'd1);
    chk("t8_lock_pre", 32'(s_lock), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("t8_rst_busy",  32'(s_busy),  32'd0);
    chk("t8_rst_lock",  32'(s_lock),  32'd0);
    chk("t8_rst_valid", 32'(s_valid), 32'd0);
    chk("t8_rst_data",  s_data,       32'd0);
    tick();
    reset_n = 1'b1;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
